key_bus_calc: RTL and testbench

- Consumer end of the keypad operand bus. Reads SRC/DST operands, the ALU opcode and the ctrl byte from the keypad entry block's tri-state bus by driving that block's write-enable.
- On each completed entry (rising edge of the finish flag) it captures the operands and runs the operation with a sequential ALU.
- Converts the magnitude to 6 BCD digits for the display stage and reports completion with a one-cycle valid pulse.

---
 rtl/key_bus_calc.sv | 200 ++++++++++++++++++++
 tb/tb_key_bus_calc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_bus_calc.sv
// Keypad operand bus consumer. It captures operands on a rising finish flag, runs a sequential ALU,
// and converts the result magnitude to 6 BCD digits.
module key_bus_calc #(
  parameter int unsigned CONV_CYCLES = 20,
  parameter int unsigned SEQ_CYCLES  = 16
) (
  input  logic        IN_clk,
  input  logic        IN_reset,
  input  logic [7:0]  IN_SRCH,
  input  logic [7:0]  IN_SRCL,
  input  logic [7:0]  IN_DSTH,
  input  logic [7:0]  IN_DSTL,
  input  logic [7:0]  IN_ALU_OP,
  input  logic [7:0]  IN_ctrl,
  output logic        OUT_wr,
  output logic [19:0] OUT_result,
  output logic [23:0] OUT_bcd,
  output logic        OUT_neg,
  output logic        OUT_err,
  output logic        OUT_busy,
  output logic        OUT_valid
);

  typedef enum logic [1:0] {IDLE, EXEC, CONV, DONE} state_t;

  state_t      state, state_nxt;
  logic        fin_hist;
  logic [15:0] a_reg, b_reg;
  logic [3:0]  op_reg;
  logic [31:0] acc, sh;
  logic [4:0]  cnt;
  logic [43:0] dd, dd_adj, dd_step;
  logic [19:0] res_q;
  logic [23:0] bcd_q;
  logic        neg_q, err_q;

  logic        trigger, seq_last, conv_last, is_div, div_zero, mul_ovf, div_ok;
  logic [31:0] mul_add;
  logic [17:0] div_diff;
  logic [15:0] rem_nxt, quo_nxt;
  logic        unused_bits;

  assign trigger   = (state == IDLE) && IN_ctrl[7] && !fin_hist;
  assign seq_last  = (cnt == 5'(SEQ_CYCLES - 1));
  assign conv_last = (cnt == 5'(CONV_CYCLES - 1));
  assign is_div    = (op_reg == 4'hD) || (op_reg == 4'hE);
  assign div_zero  = is_div && (cnt == '0) && (b_reg == '0);

  // Multiply: b_reg is consumed LSB-first while sh holds the shifted multiplicand.
  assign mul_add = b_reg[0] ? (acc + sh) : acc;
  assign mul_ovf = (mul_add > 32'd999999);

  // Divide: sh[15:0] shifts the dividend out and the quotient in, and acc[15:0] is the remainder.
  assign div_diff = {1'b0, acc[15:0], sh[15]} - {2'b00, b_reg};
  assign div_ok   = !div_diff[17];
  assign rem_nxt  = div_ok ? div_diff[15:0] : {acc[14:0], sh[15]};
  assign quo_nxt  = {sh[14:0], div_ok};

  always_comb begin
    dd_adj = dd;
    for (int unsigned i = 0; i < 6; i++) begin
      if (dd[20 + 4*i +: 4] >= 4'd5) dd_adj[20 + 4*i +: 4] = dd[20 + 4*i +: 4] + 4'd3;
    end
    dd_step = {dd_adj[42:0], 1'b0};
  end

  assign unused_bits = ^{IN_ALU_OP[7:4], IN_ctrl[6:0], div_diff[16], dd_adj[43]};

  always_ff @(posedge IN_clk or negedge IN_reset) begin
    if (!IN_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (trigger) state_nxt = EXEC;
      EXEC: begin
        case (op_reg)
          4'hA, 4'hB: state_nxt = CONV;
          4'hC:       if (seq_last) state_nxt = mul_ovf ? DONE : CONV;
          4'hD, 4'hE: begin
            if (div_zero)      state_nxt = DONE;
            else if (seq_last) state_nxt = CONV;
          end
          default:    state_nxt = DONE;
        endcase
      end
      CONV:    if (conv_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge IN_clk or negedge IN_reset) begin
    if (!IN_reset) begin
      fin_hist <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= '0;
      acc      <= '0;
      sh       <= '0;
      cnt      <= '0;
      dd       <= '0;
      res_q    <= '0;
      bcd_q    <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          fin_hist <= IN_ctrl[7];
          if (trigger) begin
            a_reg  <= {IN_SRCH, IN_SRCL};
            b_reg  <= {IN_DSTH, IN_DSTL};
            op_reg <= IN_ALU_OP[3:0];
            acc    <= '0;
            sh     <= {16'h0000, IN_SRCH, IN_SRCL};
            cnt    <= '0;
            neg_q  <= 1'b0;
            err_q  <= 1'b0;
          end
        end
        EXEC: begin
          case (op_reg)
            4'hA: begin
              res_q <= 20'(a_reg) + 20'(b_reg);
              dd    <= {24'h0, 20'(a_reg) + 20'(b_reg)};
              cnt   <= '0;
            end
            4'hB: begin
              if (b_reg > a_reg) begin
                res_q <= 20'(b_reg - a_reg);
                dd    <= {24'h0, 20'(b_reg - a_reg)};
                neg_q <= 1'b1;
              end else begin
                res_q <= 20'(a_reg - b_reg);
                dd    <= {24'h0, 20'(a_reg - b_reg)};
              end
              cnt <= '0;
            end
            4'hC: begin
              acc   <= mul_add;
              sh    <= {sh[30:0], 1'b0};
              b_reg <= {1'b0, b_reg[15:1]};
              cnt   <= cnt + 5'd1;
              if (seq_last) begin
                cnt <= '0;
                if (mul_ovf) begin
                  err_q <= 1'b1;
                  res_q <= '0;
                  bcd_q <= '0;
                end else begin
                  res_q <= mul_add[19:0];
                  dd    <= {24'h0, mul_add[19:0]};
                end
              end
            end
            4'hD, 4'hE: begin
              if (div_zero) begin
                err_q <= 1'b1;
                res_q <= '0;
                bcd_q <= '0;
              end else begin
                acc <= {16'h0000, rem_nxt};
                sh  <= {16'h0000, quo_nxt};
                cnt <= cnt + 5'd1;
                if (seq_last) begin
                  cnt   <= '0;
                  res_q <= (op_reg == 4'hD) ? {4'h0, quo_nxt} : {4'h0, rem_nxt};
                  dd    <= {24'h0, (op_reg == 4'hD) ? {4'h0, quo_nxt} : {4'h0, rem_nxt}};
                end
              end
            end
            default: begin
              err_q <= 1'b1;
              res_q <= '0;
              bcd_q <= '0;
            end
          endcase
        end
        CONV: begin
          dd  <= dd_step;
          cnt <= cnt + 5'd1;
          if (conv_last) bcd_q <= dd_step[43:20];
        end
        default: ;
      endcase
    end
  end

  assign OUT_wr     = (state == IDLE);
  assign OUT_busy   = (state != IDLE);
  assign OUT_valid  = (state == DONE);
  assign OUT_result = res_q;
  assign OUT_bcd    = bcd_q;
  assign OUT_neg    = neg_q;
  assign OUT_err    = err_q;

endmodule

// File: tb/tb_key_bus_calc.sv
// Scoreboard bench for key_bus_calc. The driver pushes expected results from a decimal reference model,
// and the monitor pops and compares them on each OUT_valid pulse.
module tb_key_bus_calc;

  logic        IN_clk = 1'b0;
  logic        IN_reset = 1'b0;
  logic [7:0]  IN_SRCH, IN_SRCL, IN_DSTH, IN_DSTL, IN_ALU_OP, IN_ctrl;
  logic        OUT_wr, OUT_neg, OUT_err, OUT_busy, OUT_valid;
  logic [19:0] OUT_result;
  logic [23:0] OUT_bcd;

  key_bus_calc #(.CONV_CYCLES(20), .SEQ_CYCLES(16)) dut (
    .IN_clk(IN_clk), .IN_reset(IN_reset),
    .IN_SRCH(IN_SRCH), .IN_SRCL(IN_SRCL), .IN_DSTH(IN_DSTH), .IN_DSTL(IN_DSTL),
    .IN_ALU_OP(IN_ALU_OP), .IN_ctrl(IN_ctrl),
    .OUT_wr(OUT_wr), .OUT_result(OUT_result), .OUT_bcd(OUT_bcd), .OUT_neg(OUT_neg),
    .OUT_err(OUT_err), .OUT_busy(OUT_busy), .OUT_valid(OUT_valid)
  );

  always #5 IN_clk = ~IN_clk;

  int cycle = 0;
  always @(posedge IN_clk) cycle <= cycle + 1;

  typedef struct {
    logic [19:0] res;
    logic [23:0] bcd;
    logic        neg;
    logic        err;
    int          lat;
    int          k;
  } exp_t;

  exp_t sbq[$];
  exp_t last_exp;
  int   checks = 0;
  int   failures = 0;

  function automatic void chk(input string name, input longint unsigned act, input longint unsigned expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  function automatic exp_t model(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    longint unsigned r, tmp;
    e.neg = 1'b0;
    e.err = 1'b0;
    e.k   = 0;
    e.bcd = '0;
    r     = 0;
    case (op[3:0])
      4'hA: begin r = longint'(a) + longint'(b); e.lat = 21; end
      4'hB: begin
        if (b > a) begin r = longint'(b) - longint'(a); e.neg = 1'b1; end
        else r = longint'(a) - longint'(b);
        e.lat = 21;
      end
      4'hC: begin
        r = longint'(a) * longint'(b);
        if (r > 999999) begin r = 0; e.err = 1'b1; e.lat = 16; end
        else e.lat = 36;
      end
      4'hD, 4'hE: begin
        if (b == 0) begin e.err = 1'b1; e.lat = 1; end
        else begin r = (op[3:0] == 4'hD) ? (a / b) : (a % b); e.lat = 36; end
      end
      default: begin e.err = 1'b1; e.lat = 1; end
    endcase
    e.res = 20'(r);
    tmp = r;
    for (int i = 0; i < 6; i++) begin
      e.bcd[i*4 +: 4] = 4'(tmp % 10);
      tmp = tmp / 10;
    end
    return e;
  endfunction

  task automatic drive_bus(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b, input logic fin);
    IN_SRCH   = a[15:8];
    IN_SRCL   = a[7:0];
    IN_DSTH   = b[15:8];
    IN_DSTL   = b[7:0];
    IN_ALU_OP = op;
    IN_ctrl   = {fin, 7'($urandom)};
  endtask

  task automatic scramble_bus();
    drive_bus(8'($urandom), 16'($urandom), 16'($urandom), 1'b1);
  endtask

  task automatic start_op(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    @(negedge IN_clk);
    drive_bus(op, a, b, 1'b0);
    @(negedge IN_clk);
    drive_bus(op, a, b, 1'b1);
    e = model(op, a, b);
    e.k = cycle + 1;
    sbq.push_back(e);
    last_exp = e;
  endtask

  // Garbage goes on the bus while busy; finish stays high through DONE and a few idle cycles.
  task automatic finish_op();
    int n;
    @(negedge IN_clk);
    chk("busy_at_capture", OUT_busy, 1);
    chk("wr_low_when_busy", OUT_wr, 0);
    n = 0;
    while (OUT_busy && n < 80) begin
      scramble_bus();
      @(negedge IN_clk);
      n++;
    end
    chk("done_within_budget", OUT_busy, 0);
    repeat (3) begin
      @(negedge IN_clk);
      chk("no_retrigger", OUT_busy, 0);
    end
    chk("hold_result", OUT_result, last_exp.res);
    chk("wr_high_idle", OUT_wr, 1);
    IN_ctrl = {1'b0, IN_ctrl[6:0]};
  endtask

  task automatic run_op(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    start_op(op, a, b);
    finish_op();
  endtask

  task automatic check_reset_outputs();
    chk("rst_result", OUT_result, 0);
    chk("rst_bcd", OUT_bcd, 0);
    chk("rst_neg", OUT_neg, 0);
    chk("rst_err", OUT_err, 0);
    chk("rst_busy", OUT_busy, 0);
    chk("rst_valid", OUT_valid, 0);
    chk("rst_wr", OUT_wr, 1);
  endtask

  always @(negedge IN_clk) begin
    if (OUT_valid) begin
      if (sbq.size() == 0) begin
        chk("unexpected_valid", OUT_valid, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("result", OUT_result, e.res);
        chk("bcd", OUT_bcd, e.bcd);
        chk("neg", OUT_neg, e.neg);
        chk("err", OUT_err, e.err);
        chk("latency", longint'(cycle - e.k), longint'(e.lat));
      end
    end
  end

  initial begin
    logic [7:0]  op;
    logic [15:0] a, b;
    int          sel;

    drive_bus(8'h00, 16'h0, 16'h0, 1'b0);
    repeat (3) @(negedge IN_clk);
    check_reset_outputs();
    IN_reset = 1'b1;

    run_op(8'h0A, 16'd123,   16'd456);
    run_op(8'h0B, 16'd12,    16'd345);
    run_op(8'h0B, 16'd345,   16'd12);
    run_op(8'hEB, 16'd0,     16'd0);
    run_op(8'h5A, 16'd65535, 16'd65535);
    run_op(8'h0C, 16'd999,   16'd999);
    run_op(8'h0C, 16'd1000,  16'd1000);
    run_op(8'h0C, 16'd1001,  16'd999);
    run_op(8'hFC, 16'd65535, 16'd1);
    run_op(8'h0D, 16'd999,   16'd7);
    run_op(8'h0E, 16'd999,   16'd7);
    run_op(8'h0D, 16'd7,     16'd999);
    run_op(8'h0E, 16'd7,     16'd999);
    run_op(8'h0D, 16'd65535, 16'd1);
    run_op(8'h0D, 16'd500,   16'd0);
    run_op(8'h0E, 16'd500,   16'd0);
    run_op(8'h03, 16'd5,     16'd5);
    run_op(8'hAF, 16'd5,     16'd5);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      a = 16'($urandom);
      b = 16'($urandom);
      op = {4'($urandom), 4'hA};
      if (sel >= 2 && sel < 4) op[3:0] = 4'hB;
      else if (sel >= 4 && sel < 6) begin
        op[3:0] = 4'hC;
        if (sel == 4) begin a = 16'($urandom_range(0, 1500)); b = 16'($urandom_range(0, 1500)); end
      end else if (sel >= 6 && sel < 8) begin
        op[3:0] = (sel == 6) ? 4'hD : 4'hE;
        b = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
      end else if (sel >= 8) op = 8'($urandom);
      run_op(op, a, b);
    end

    // An abort in the middle of a multiply, with finish still high when reset is released.
    @(negedge IN_clk);
    drive_bus(8'h0C, 16'd999, 16'd999, 1'b0);
    @(negedge IN_clk);
    drive_bus(8'h0C, 16'd999, 16'd999, 1'b1);
    repeat (8) @(negedge IN_clk);
    chk("busy_before_reset", OUT_busy, 1);
    #1 IN_reset = 1'b0;
    #1 check_reset_outputs();
    drive_bus(8'h0A, 16'd40, 16'd2, 1'b1);
    @(negedge IN_clk);
    IN_reset = 1'b1;
    last_exp = model(8'h0A, 16'd40, 16'd2);
    last_exp.k = cycle + 1;
    sbq.push_back(last_exp);
    finish_op();

    repeat (2) @(negedge IN_clk);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
